vgacon_term: RTL
================

// Module: vgacon_term
// PURPOSE
//  Byte-stream terminal front end for the VGA text console. Consumes a valid/ready
//  character stream from the CPU/UART side and performs all writes into the text
//  RAM system port (80x50 cells, addr = row*80+col, data = {colour, ascii[6:0]}).
//  Tracks the cursor and handles control codes, line wrap and screen clearing.
//  Runs in the sysclk domain, directly upstream of the TRAM sys write port.
// PARAMETERS
//  COLS      80   text columns per row
//  ROWS      50   text rows
//  FILL_CHAR 8'h20 byte written by clear operations
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   synchronous, active-low reset
//  in_data    in   8   character byte
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block can accept a byte this cycle
//  tram_addr  out  13  TRAM write address (row*COLS+col)
//  tram_data  out  8   TRAM write data
//  tram_wren  out  1   TRAM write strobe, one cycle per write
//  cursor_x   out  7   current column, 0..COLS-1
//  cursor_y   out  6   current row, 0..ROWS-1
//  busy       out  1   clear operation in progress (== !in_ready)
// BEHAVIOUR
//  - All outputs registered. Reset: tram_addr=0, tram_data=0, tram_wren=0,
//    cursor 0,0, colour=0; FSM enters CLR_SCR (in_ready=0, busy=1).
//  - States: IDLE (in_ready=1), CLR_LINE, CLR_SCR. Accept = in_valid & in_ready.
//  - IDLE accept of 0x20..0x7E in cycle N: cycle N+1 tram_wren=1,
//    tram_addr=y*80+x, tram_data={colour,char[6:0]}; x++. Throughput 1 byte/cycle.
//    If x was COLS-1: perform newline (below) instead of x++.
//  - 0x0D CR: x=0, no write. 0x0A LF: newline. 0x08 BS: if x>0, x--, write
//    FILL_CHAR at new x next cycle; if x==0 no write, no move. 0x0C FF: cursor 0,0,
//    goto CLR_SCR. All other bytes (incl. >=0x80) consumed and ignored.
//  - Newline: x=0; y=(y==ROWS-1)?0:y+1; goto CLR_LINE to blank new row y.
//  - CLR_LINE: COLS consecutive cycles tram_wren=1, addr y*80+0..y*80+79,
//    data FILL_CHAR; then IDLE. CLR_SCR: addr 0..COLS*ROWS-1 (0..3999), one per
//    cycle, data FILL_CHAR; then IDLE. in_ready=0 throughout; no bytes lost.
//  - Printable write and triggered clear never overlap: char write occurs in cycle
//    N+1, clear writes start N+2.
//  - Address math in 13 bits; max 3999, no overflow. Cursor never leaves range.
//  - resetn low mid-clear aborts and restarts a full CLR_SCR from addr 0.
// CONFIGURATION
//  VGACON_TERM_COLOUR_EN defined: 0x0E sets colour=1, 0x0F clears colour=0;
//    colour drives tram_data[7] on character writes (clears always bit7=0).
//  Undefined: colour held 0, 0x0E/0x0F ignored like other control bytes.
// STRUCTURE
//  vgacon_pkg: COLS/ROWS/TRAM_CELLS constants, control codes (CR/LF/BS/FF/SO/SI),
//    state enum (IDLE/CLR_LINE/CLR_SCR).
//  Sub-module vgacon_term_fill: start/base/count inputs, emits sequential fill
//    addresses + done; shared by CLR_LINE and CLR_SCR.
// TESTING
//  1 Release reset -> 4000 writes addr 0..3999 data 0x20, in_ready rises after.
//  2 Send 'A','B' -> writes addr 0 data 0x41, addr 1 data 0x42; cursor_x=2.
//  3 Cursor (79,49), send 'Z' -> write addr 3999 0x5A, then clear addr 0..79,
//    cursor (0,0), in_ready low 80 cycles.
//  4 At x=0 send 0x08 -> no write; at x=5 send 0x08 -> write addr y*80+4 0x20.
//  5 COLOUR_EN: send 0x0E,'A',0x0F,'A' -> data 0xC1 then 0x41; without: 0x41 both.
//  6 Send 0x0C, pulse resetn low at clear addr 1000 -> clear restarts at addr 0.

Source files
------------

// File: rtl/vgacon_pkg.sv
// vgacon_pkg: geometry, control codes and FSM states for the text console terminal.
// The colour attribute feature is enabled with the VGACON_TERM_COLOUR_EN macro.
package vgacon_pkg;

    localparam int TERM_COLS  = 80;
    localparam int TERM_ROWS  = 50;
    localparam int TRAM_CELLS = TERM_COLS * TERM_ROWS;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SO = 8'h0E;
    localparam logic [7:0] CH_SI = 8'h0F;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLR_LINE = 2'd1;
    localparam logic [1:0] ST_CLR_SCR  = 2'd2;

    function automatic logic [12:0] cell_addr(
        input logic [5:0] y,
        input logic [6:0] x,
        input int         cols
    );
        return 13'(y) * 13'(cols) + 13'(x);
    endfunction

endpackage

// File: rtl/vgacon_term_fill.sv
// vgacon_term_fill: sequential address generator for line and screen clears.
// Emits base+offset each enabled cycle; done flags the final cell.
module vgacon_term_fill (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        en,
    input  logic [12:0] base,
    input  logic [12:0] count,
    output logic [12:0] addr,
    output logic        done
);

    logic [12:0] cnt;

    // Offset counter: parked at zero while start is held, steps per fill write
    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 13'd1;
        end
    end

    assign addr = base + cnt;
    assign done = (cnt == count - 13'd1);

endmodule

// File: rtl/vgacon_term.sv
// vgacon_term: byte-stream terminal front end driving the TRAM system write port.
// Define VGACON_TERM_COLOUR_EN to enable SO/SI colour attribute control.
module vgacon_term
    import vgacon_pkg::*;
#(
    parameter int         COLS      = TERM_COLS,
    parameter int         ROWS      = TERM_ROWS,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] tram_addr,
    output logic [7:0]  tram_data,
    output logic        tram_wren,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    logic [1:0]  state;
    logic        colour;
    logic        accept;
    logic        is_print;
    logic        at_eol;
    logic [5:0]  y_next;
    logic [12:0] cur_addr;
    logic        clearing;
    logic [12:0] fill_base;
    logic [12:0] fill_count;
    logic [12:0] fill_addr;
    logic        fill_done;

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid & in_ready;
    assign clearing = (state == ST_CLR_LINE) || (state == ST_CLR_SCR);

    assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign at_eol   = (cursor_x == 7'(COLS - 1));
    assign y_next   = (cursor_y == 6'(ROWS - 1)) ? 6'd0 : cursor_y + 6'd1;
    assign cur_addr = cell_addr(cursor_y, cursor_x, COLS);

    assign fill_base  = (state == ST_CLR_LINE) ? cell_addr(cursor_y, 7'd0, COLS)
                                               : 13'd0;
    assign fill_count = (state == ST_CLR_LINE) ? 13'(COLS) : 13'(COLS * ROWS);

    vgacon_term_fill u_fill (
        .clk    (clk),
        .resetn (resetn),
        .start  (in_ready),
        .en     (clearing),
        .base   (fill_base),
        .count  (fill_count),
        .addr   (fill_addr),
        .done   (fill_done)
    );

`ifdef VGACON_TERM_COLOUR_EN
    // Colour attribute latched from SO (set) and SI (clear)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            colour <= 1'b0;
        end else if (accept && in_data == CH_SO) begin
            colour <= 1'b1;
        end else if (accept && in_data == CH_SI) begin
            colour <= 1'b0;
        end
    end
`else
    assign colour = 1'b0;
`endif

    // Byte decode, cursor tracking and clear sequencing; all writes registered
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_CLR_SCR;
            cursor_x  <= '0;
            cursor_y  <= '0;
            tram_addr <= '0;
            tram_data <= '0;
            tram_wren <= 1'b0;
        end else begin
            tram_wren <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        unique case (1'b1)
                            is_print: begin
                                tram_wren <= 1'b1;
                                tram_addr <= cur_addr;
                                tram_data <= {colour, in_data[6:0]};
                                if (at_eol) begin
                                    cursor_x <= '0;
                                    cursor_y <= y_next;
                                    state    <= ST_CLR_LINE;
                                end else begin
                                    cursor_x <= cursor_x + 7'd1;
                                end
                            end
                            (in_data == CH_CR): begin
                                cursor_x <= '0;
                            end
                            (in_data == CH_LF): begin
                                cursor_x <= '0;
                                cursor_y <= y_next;
                                state    <= ST_CLR_LINE;
                            end
                            (in_data == CH_BS): begin
                                if (cursor_x != 7'd0) begin
                                    cursor_x  <= cursor_x - 7'd1;
                                    tram_wren <= 1'b1;
                                    tram_addr <= cell_addr(cursor_y,
                                                           cursor_x - 7'd1,
                                                           COLS);
                                    tram_data <= FILL_CHAR;
                                end
                            end
                            (in_data == CH_FF): begin
                                cursor_x <= '0;
                                cursor_y <= '0;
                                state    <= ST_CLR_SCR;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLR_LINE, ST_CLR_SCR: begin
                    tram_wren <= 1'b1;
                    tram_addr <= fill_addr;
                    tram_data <= FILL_CHAR;
                    if (fill_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_CLR_SCR;
                end
            endcase
        end
    end

endmodule
